// File: rtl/addsub_checker.sv
// Self-test sequencer for a 4-bit adder-subtractor: sweeps all 512 {ctr, A, B} vectors and scores the responses.
// Optional build macro ADDSUB_CHK_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module addsub_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_ctr,
    input  logic [3:0] dut_s,
    input  logic       dut_sign,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_fail
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [8:0] IDX_LAST  = 9'd511;

    state_t     state_r;
    state_t     state_s;
    logic [8:0] idx_r;
    logic [3:0] wait_cnt_r;
    logic [9:0] err_count_r;
    logic [8:0] first_fail_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic       start_ok_s;
    logic       mismatch_s;
    logic       stop_s;
    logic [5:0] expect_s;

    // Reference response packed as {sign, cout, s}; subtraction reports a magnitude plus sign.
    function automatic logic [5:0] golden_resp(input logic ctr, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        logic [5:0] resp;
        sum = {1'b0, a} + {1'b0, b};
        if (!ctr) begin
            resp = {1'b0, sum[4], sum[3:0]};
        end else if (a >= b) begin
            resp = {1'b0, 1'b1, a - b};
        end else begin
            resp = {1'b1, 1'b0, b - a};
        end
        return resp;
    endfunction

    // Compare the current response against the golden model and decide early termination.
    always_comb begin
        expect_s   = golden_resp(idx_r[8], idx_r[7:4], idx_r[3:0]);
        mismatch_s = ({dut_sign, dut_cout, dut_s} != expect_s);
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
        stop_s     = mismatch_s;
`else
        stop_s     = 1'b0;
`endif
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DRIVE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == SETTLE_M1) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if ((idx_r == IDX_LAST) || stop_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
        end
    end

    // Vector index: cleared on an accepted start, advanced when a check hands over to the next drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= 9'd0;
        end else if (start_ok_s) begin
            idx_r <= 9'd0;
        end else if ((state_r == ST_CHECK) && (state_s == ST_DRIVE)) begin
            idx_r <= idx_r + 9'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Mismatch tally; first_fail latches only while the tally is still zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r  <= 10'd0;
            first_fail_r <= 9'd0;
        end else if (start_ok_s) begin
            err_count_r  <= 10'd0;
            first_fail_r <= 9'd0;
        end else if ((state_r == ST_CHECK) && mismatch_s) begin
            err_count_r <= err_count_r + 10'd1;
            if (err_count_r == 10'd0) begin
                first_fail_r <= idx_r;
            end else begin
                first_fail_r <= first_fail_r;
            end
        end else begin
            err_count_r  <= err_count_r;
            first_fail_r <= first_fail_r;
        end
    end

    // Status flags; done trails DONE entry by one cycle so err_count is final when it rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_DRIVE) || (state_s == ST_WAIT) || (state_s == ST_CHECK);
            done_r <= (state_r == ST_DONE) && !start_ok_s;
            pass_r <= (state_r == ST_DONE) && !start_ok_s && (err_count_r == 10'd0);
        end
    end

    assign dut_ctr    = idx_r[8];
    assign dut_a      = idx_r[7:4];
    assign dut_b      = idx_r[3:0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_count_r;
    assign first_fail = first_fail_r;

endmodule

// File: tb/tb_addsub_checker.sv
// Scoreboard bench for addsub_checker: a behavioural adder-subtractor with injectable faults stands in
// for the unit under test; predicted run results are queued at start and popped when done rises.
module tb_addsub_checker;

    localparam int SETTLE = 1;

    typedef struct {
        int err;
        int ff;
        int pss;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dut_a;
    logic [3:0] dut_b;
    logic       dut_ctr;
    logic [3:0] dut_s;
    logic       dut_sign;
    logic       dut_cout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [9:0] err_count;
    logic [8:0] first_fail;

    int         fault_mode = 0;
    int         fault_idx  = 0;
    int         fault_mask = 0;
    int         checks     = 0;
    int         fails      = 0;
    int         cyc        = 0;
    int         start_cyc  = 0;
    logic       done_q     = 1'b0;
    exp_t       q[$];

    addsub_checker #(.SETTLE(SETTLE)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .dut_ctr    (dut_ctr),
        .dut_s      (dut_s),
        .dut_sign   (dut_sign),
        .dut_cout   (dut_cout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal response as {sign, cout, s} from plain integer arithmetic.
    function automatic int ideal(input int v);
        int ctr, a, b, sum;
        ctr = v / 256;
        a   = (v / 16) % 16;
        b   = v % 16;
        if (ctr == 0) begin
            sum = a + b;
            return ((sum / 16) * 16) + (sum % 16);
        end
        if (a >= b) return 16 + (a - b);
        return 32 + (b - a);
    endfunction

    // Adder-subtractor under test with a selectable fault.
    function automatic int faulty(input int mode, input int v, input int fidx, input int fmask);
        int r;
        r = ideal(v);
        case (mode)
            1: r = r & 31;                              // sign stuck at 0
            2: r = r | 16;                              // cout stuck at 1
            3: if (v == fidx) r = r ^ (fmask & 15);     // single corrupted vector
            default: r = r;
        endcase
        return r;
    endfunction

    always_comb begin
        int r;
        r = faulty(fault_mode, int'({dut_ctr, dut_a, dut_b}), fault_idx, fault_mask);
        dut_s    = 4'(r % 16);
        dut_cout = 1'((r / 16) % 2);
        dut_sign = 1'(r / 32);
    end

    function automatic exp_t predict(input int mode, input int fidx, input int fmask);
        exp_t e;
        int   nvec;
        e.err = 0;
        e.ff  = 0;
        nvec  = 512;
        for (int i = 0; i < 512; i++) begin
            if (faulty(mode, i, fidx, fmask) != ideal(i)) begin
                if (e.err == 0) e.ff = i;
                e.err++;
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
                nvec = i + 1;
                break;
`endif
            end
        end
        e.pss = (e.err == 0) ? 1 : 0;
        e.lat = 1 + nvec * (SETTLE + 2);
        return e;
    endfunction

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: score each completed run against the oldest queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (q.size() == 0) begin
                compare("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                compare("err_count", int'(err_count), e.err);
                compare("first_fail", int'(first_fail), e.ff);
                compare("pass", int'(pass), e.pss);
                compare("latency", cyc - start_cyc, e.lat);
                compare("busy_at_done", int'(busy), 0);
            end
        end
        done_q <= done;
    end

    task automatic check_all_zero(input string tag);
        compare({tag, "_busy"}, int'(busy), 0);
        compare({tag, "_done"}, int'(done), 0);
        compare({tag, "_pass"}, int'(pass), 0);
        compare({tag, "_err"}, int'(err_count), 0);
        compare({tag, "_ff"}, int'(first_fail), 0);
        compare({tag, "_vec"}, int'({dut_ctr, dut_a, dut_b}), 0);
    endtask

    task automatic kick(input int mode, input int fidx, input int fmask);
        @(negedge clk);
        fault_mode = mode;
        fault_idx  = fidx;
        fault_mask = fmask;
        q.push_back(predict(mode, fidx, fmask));
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        compare("start_done_low", int'(done), 0);
        compare("start_busy", int'(busy), 1);
        compare("start_err_clr", int'(err_count), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            compare("run_timeout", 0, 1);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        kick(0, 0, 0);  wait_done();
        kick(1, 0, 0);  wait_done();
        kick(2, 0, 0);  wait_done();

        repeat (4) begin
            kick(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)), int'($urandom_range(1, 15)));
            wait_done();
        end

        // start while busy must not restart or delay the run
        kick(0, 0, 0);
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset around vector 100 abandons the run
        kick(1, 0, 0);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        kick(0, 0, 0);  wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/addsub_checker.md
ADDSUB_CHECKER -- requirements
Module: addsub_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1: wait cycles between driving a vector and sampling the response; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: begins a test run when sampled high in IDLE or DONE.
REQ-005 SHALL have ports dut_a and dut_b, output, 4 each: A and B operands to the adder-subtractor under test.
REQ-006 SHALL have port dut_ctr, output, 1: operation select to the adder-subtractor; 0 = add, 1 = subtract.
REQ-007 SHALL have ports dut_s (input, 4), dut_sign (input, 1) and dut_cout (input, 1): adder-subtractor response.
REQ-008 SHALL have ports busy (output, 1), done (output, 1) and pass (output, 1): run status.
REQ-009 SHALL have ports err_count (output, 10) and first_fail (output, 9): mismatch total, and the index of the first failing vector.

Function
REQ-010 SHALL hold a 9-bit vector index idx.
- dut_ctr = idx[8], dut_a = idx[7:4], dut_b = idx[3:0].
- All three outputs come directly from registers.
REQ-011 SHALL run the FSM states IDLE, DRIVE, WAIT, CHECK and DONE.
- IDLE/DONE with start -> DRIVE; idx, err_count and first_fail cleared.
- DRIVE -> WAIT.
- WAIT lasts SETTLE cycles, then -> CHECK.
- CHECK at idx = 511 -> DONE; otherwise idx+1 and -> DRIVE.
REQ-012 SHALL use this golden model when ctr = 0:
- {cout, s} = A + B;
- sign = 0.
REQ-013 SHALL use this golden model when ctr = 1:
- A >= B: s = A - B, cout = 1, sign = 0;
- A < B: s = B - A (magnitude), cout = 0, sign = 1.
REQ-014 SHALL compare dut_s, dut_sign and dut_cout against the golden model in CHECK.
- Any difference increments err_count.
- On the first mismatch of a run, first_fail captures idx.
REQ-015 SHALL assert busy in DRIVE, WAIT and CHECK.
REQ-016 SHALL assert done only in DONE; done holds until the next start or reset.
REQ-017 SHALL drive pass = done AND (err_count == 0).
REQ-018 SHALL make done rise 1 + 512*(SETTLE+2) cycles after the edge that samples start (1537 cycles at SETTLE = 1).
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL hold first_fail at 0 when err_count = 0.

Reset
REQ-021 SHALL, while rst is high and independent of clk, force:
- state = IDLE, idx = 0;
- dut_a = dut_b = 0, dut_ctr = 0;
- busy = done = pass = 0;
- err_count = 0, first_fail = 0.
REQ-022 SHALL, on reset mid-run, abandon the run with no partial status retained; the next start runs all 512 vectors.

Configuration
REQ-023 SHALL, with ADDSUB_CHK_STOP_ON_FAIL_EN defined, move from CHECK to DONE on the first mismatch; err_count = 1 and first_fail = failing idx.
REQ-024 SHALL, without ADDSUB_CHK_STOP_ON_FAIL_EN, always run all 512 vectors and count every mismatch.

Verification
REQ-025 Correct DUT model, SETTLE = 1, start pulse -> done at +1537 cycles, pass = 1, err_count = 0.
REQ-026 DUT with sign stuck at 0, macro undefined -> err_count = 120, first_fail = 257 (ctr = 1, A = 0, B = 1), pass = 0.
REQ-027 Same fault, macro defined -> done after vector 257 is checked, err_count = 1, first_fail = 257.
REQ-028 DUT with cout stuck at 1, macro undefined -> err_count = 256 (136 add + 120 subtract), first_fail = 0.
REQ-029 rst pulsed at idx ≈ 100 -> all outputs 0 immediately; a following start completes in 1537 cycles with the correct result.
REQ-030 start pulsed while busy -> no effect, completion time unchanged; start in DONE -> restart with err_count cleared and done low next cycle.
